// File: rtl/hilo_pkg.sv
// Shared types for the Hi/Lo multiply/divide sequencer: command encoding and FSM states.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    DIV_RUN = 2'b10,
    FIX     = 2'b11
  } state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Command/result bundle between the main control unit (master) and the Hi/Lo sequencer (slave).
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  import hilo_pkg::*;

  logic             OpValid;
  op_e              Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output OpValid, Op, OpA, OpB,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  OpValid, Op, OpA, OpB,
    output Busy, Done, DivZero, Hi, Lo
  );

endinterface

// File: rtl/muldiv_step_dp.sv
// One iteration of either a radix-2 Booth multiply or a restoring divide, purely combinational.
// Multiply view of pair: the (2*WIDTH+1)-bit Booth P register.
// Divide view of pair: remainder magnitude in [2*WIDTH-1:WIDTH], quotient in [WIDTH-1:0].
module muldiv_step_dp #(
  parameter int WIDTH = 32
) (
  input  logic               divMode_i,
  input  logic [2*WIDTH:0]   pair_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   pair_o
);

  logic [2*WIDTH+1:0] pExt;
  logic [2*WIDTH+1:0] aExt;
  logic [2*WIDTH+1:0] sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   newRem;
  logic               qBit;
  logic               unusedBits;

  // Booth step carried one bit wider than P so that adding S for the most negative
  // multiplicand keeps its true sign through the arithmetic shift.
  always_comb begin
    pExt = {pair_i[2*WIDTH], pair_i};
    aExt = {opnd_i[WIDTH-1], opnd_i, {(WIDTH+1){1'b0}}};
    sum  = pExt;
    unique case (pair_i[1:0])
      2'b01:   sum = pExt + aExt;
      2'b10:   sum = pExt - aExt;
      default: sum = pExt;
    endcase
  end

  // Restoring divide step: shift the pair left, trial-subtract, keep the difference if non-negative.
  always_comb begin
    shifted = {pair_i[2*WIDTH-1:WIDTH], pair_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    qBit    = ~diff[WIDTH+1];
    newRem  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  // Select the result for the active operation.
  always_comb begin
    if (divMode_i) begin
      pair_o = {1'b0, newRem, pair_i[WIDTH-2:0], qBit};
    end else begin
      pair_o = sum[2*WIDTH+1:1];
    end
  end

  assign unusedBits = sum[0] ^ diff[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Hi/Lo owner and multicycle MULT/DIV sequencer; WIDTH iterations then one sign-fix cycle.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic              Clk_i,
  input logic              Reset_i,
  hilo_muldiv_ctrl_if.slave bus
);
  import hilo_pkg::*;

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CntMax   = CW'(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   pair_q;
  logic [2*WIDTH:0]   pairNext;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               signA_q, signB_q, isDiv_q;
  logic               done_q, divZero_q;
  logic [WIDTH-1:0]   quoMag, remMag, quoSigned, remSigned;

  muldiv_step_dp #(.WIDTH(WIDTH)) u_step (
    .divMode_i (state_q == DIV_RUN),
    .pair_i    (pair_q),
    .opnd_i    (opnd_q),
    .pair_o    (pairNext)
  );

  // Sign correction of the divide magnitudes. With a zero divisor every trial succeeds,
  // so the remainder ends up holding |OpA| and remSigned restores the original dividend.
  always_comb begin
    quoMag    = pair_q[WIDTH-1:0];
    remMag    = pair_q[2*WIDTH-1:WIDTH];
    quoSigned = (signA_q ^ signB_q) ? -quoMag : quoMag;
    remSigned = signA_q ? -remMag : remMag;
  end

  // FSM state register.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: only MULT/DIV leave IDLE, the last iteration hands over to FIX.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.OpValid && bus.Op == OP_MULT) state_d = MUL_RUN;
        if (bus.OpValid && bus.Op == OP_DIV)  state_d = DIV_RUN;
      end
      MUL_RUN, DIV_RUN: if (cnt_q == LastStep) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: Busy straight from the state, everything else straight from registers.
  always_comb begin
    bus.Busy    = (state_q != IDLE);
    bus.Done    = done_q;
    bus.DivZero = divZero_q;
    bus.Hi      = hi_q;
    bus.Lo      = lo_q;
  end

  // Operand latch, iteration datapath, saturating counter and Hi/Lo writes.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      cnt_q     <= '0;
      pair_q    <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      isDiv_q   <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.OpValid) begin
            unique case (bus.Op)
              OP_MULT: begin
                opnd_q  <= bus.OpA;
                pair_q  <= {{WIDTH{1'b0}}, bus.OpB, 1'b0};
                cnt_q   <= '0;
                isDiv_q <= 1'b0;
              end
              OP_DIV: begin
                opnd_q  <= bus.OpB[WIDTH-1] ? -bus.OpB : bus.OpB;
                pair_q  <= {{(WIDTH+1){1'b0}}, (bus.OpA[WIDTH-1] ? -bus.OpA : bus.OpA)};
                signA_q <= bus.OpA[WIDTH-1];
                signB_q <= bus.OpB[WIDTH-1];
                cnt_q   <= '0;
                isDiv_q <= 1'b1;
              end
              OP_MTHI: hi_q <= bus.OpA;
              OP_MTLO: lo_q <= bus.OpA;
              default: ;
            endcase
          end
        end
        MUL_RUN, DIV_RUN: begin
          pair_q <= pairNext;
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (!isDiv_q) begin
            {hi_q, lo_q} <= pair_q[2*WIDTH:1];
          end else if (opnd_q == '0) begin
            hi_q      <= remSigned;
            lo_q      <= '1;
            divZero_q <= 1'b1;
          end else begin
            hi_q <= remSigned;
            lo_q <= quoSigned;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: hand-computed MULT/DIV/MTHI/MTLO results, timing and reset abort.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus();

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .Clk_i   (clk),
    .Reset_i (reset),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Present one command for a single cycle starting at the current falling edge.
  task automatic drive(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.OpValid = 1'b1;
    bus.Op      = op;
    bus.OpA     = a;
    bus.OpB     = b;
    @(negedge clk);
    bus.OpValid = 1'b0;
  endtask

  // Issue a command and return at the falling edge of the first non-busy cycle.
  task automatic runOp(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int busyCycles, output int earlyDone);
    drive(op, a, b);
    busyCycles = 0;
    earlyDone  = 0;
    while (bus.Busy === 1'b1 && busyCycles < 200) begin
      busyCycles++;
      if (bus.Done !== 1'b0) earlyDone++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.Busy); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.Done); end
    total++; if (bus.DivZero !== 1'b0) begin bad++; $display("[TB] FAIL reset_divzero: got %b want 0", bus.DivZero); end
    total++; if (bus.Hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h want 0", bus.Hi); end
    total++; if (bus.Lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h want 0", bus.Lo); end
  endtask

  task automatic test_mult_basic;
    int cyc, early;
    runOp(OP_MULT, 32'd7, 32'hFFFFFFFD, cyc, early);
    total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL mult_busy_cycles: got %0d want 33", cyc); end
    total++; if (early !== 0) begin bad++; $display("[TB] FAIL mult_early_done: got %0d want 0", early); end
    total++; if (bus.Done !== 1'b1) begin bad++; $display("[TB] FAIL mult_done: got %b want 1", bus.Done); end
    total++; if (bus.DivZero !== 1'b0) begin bad++; $display("[TB] FAIL mult_divzero: got %b want 0", bus.DivZero); end
    total++; if (bus.Hi !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mult_hi: got %h want FFFFFFFF", bus.Hi); end
    total++; if (bus.Lo !== 32'hFFFFFFEB) begin bad++; $display("[TB] FAIL mult_lo: got %h want FFFFFFEB", bus.Lo); end
    @(negedge clk);
    total++; if (bus.Done !== 1'b0) begin bad++; $display("[TB] FAIL mult_done_pulse: got %b want 0", bus.Done); end
  endtask

  task automatic test_mult_vectors;
    logic [W-1:0] va [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h000186A0};
    logic [W-1:0] vb [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h000493E0};
    logic [W-1:0] eh [3] = '{32'h40000000, 32'h00000000, 32'h00000006};
    logic [W-1:0] el [3] = '{32'h00000000, 32'h00000001, 32'hFC23AC00};
    int cyc, early;
    for (int i = 0; i < 3; i++) begin
      runOp(OP_MULT, va[i], vb[i], cyc, early);
      total++; if (bus.Hi !== eh[i]) begin bad++; $display("[TB] FAIL mult_vec%0d_hi: got %h want %h", i, bus.Hi, eh[i]); end
      total++; if (bus.Lo !== el[i]) begin bad++; $display("[TB] FAIL mult_vec%0d_lo: got %h want %h", i, bus.Lo, el[i]); end
    end
  endtask

  task automatic test_div_vectors;
    logic [W-1:0] va [4] = '{32'hFFFFFFF9, 32'd7,        32'h80000000, 32'd100};
    logic [W-1:0] vb [4] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
    logic [W-1:0] eh [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000002};
    logic [W-1:0] el [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0000000E};
    int cyc, early;
    for (int i = 0; i < 4; i++) begin
      runOp(OP_DIV, va[i], vb[i], cyc, early);
      total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL div_vec%0d_busy_cycles: got %0d want 33", i, cyc); end
      total++; if (bus.Done !== 1'b1) begin bad++; $display("[TB] FAIL div_vec%0d_done: got %b want 1", i, bus.Done); end
      total++; if (bus.DivZero !== 1'b0) begin bad++; $display("[TB] FAIL div_vec%0d_divzero: got %b want 0", i, bus.DivZero); end
      total++; if (bus.Hi !== eh[i]) begin bad++; $display("[TB] FAIL div_vec%0d_hi: got %h want %h", i, bus.Hi, eh[i]); end
      total++; if (bus.Lo !== el[i]) begin bad++; $display("[TB] FAIL div_vec%0d_lo: got %h want %h", i, bus.Lo, el[i]); end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] va [2] = '{32'd5, 32'hFFFFFFFB};
    int cyc, early;
    for (int i = 0; i < 2; i++) begin
      runOp(OP_DIV, va[i], 32'd0, cyc, early);
      total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL divzero%0d_busy_cycles: got %0d want 33", i, cyc); end
      total++; if (bus.Done !== 1'b1) begin bad++; $display("[TB] FAIL divzero%0d_done: got %b want 1", i, bus.Done); end
      total++; if (bus.DivZero !== 1'b1) begin bad++; $display("[TB] FAIL divzero%0d_flag: got %b want 1", i, bus.DivZero); end
      total++; if (bus.Hi !== va[i]) begin bad++; $display("[TB] FAIL divzero%0d_hi: got %h want %h", i, bus.Hi, va[i]); end
      total++; if (bus.Lo !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL divzero%0d_lo: got %h want FFFFFFFF", i, bus.Lo); end
      @(negedge clk);
      total++; if (bus.DivZero !== 1'b0) begin bad++; $display("[TB] FAIL divzero%0d_pulse: got %b want 0", i, bus.DivZero); end
    end
  endtask

  task automatic test_mthi_mtlo;
    bus.OpValid = 1'b1;
    bus.Op      = OP_MTHI;
    bus.OpA     = 32'h00001234;
    @(negedge clk);
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b want 0", bus.Busy); end
    bus.Op      = OP_MTLO;
    bus.OpA     = 32'h0000ABCD;
    @(negedge clk);
    bus.OpValid = 1'b0;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_busy: got %b want 0", bus.Busy); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_done: got %b want 0", bus.Done); end
    total++; if (bus.Hi !== 32'h00001234) begin bad++; $display("[TB] FAIL mthi_value: got %h want 00001234", bus.Hi); end
    total++; if (bus.Lo !== 32'h0000ABCD) begin bad++; $display("[TB] FAIL mtlo_value: got %h want 0000ABCD", bus.Lo); end
  endtask

  task automatic test_ignore_while_busy;
    int cyc = 0;
    drive(OP_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(negedge clk);
    bus.OpValid = 1'b1;
    bus.Op      = OP_MTHI;
    bus.OpA     = 32'h00005555;
    @(negedge clk);
    bus.OpValid = 1'b0;
    total++; if (bus.Hi !== 32'h00001234) begin bad++; $display("[TB] FAIL ignore_hi_midrun: got %h want 00001234", bus.Hi); end
    while (bus.Busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    total++; if (cyc >= 200) begin bad++; $display("[TB] FAIL ignore_timeout: got %0d cycles want <200", cyc); end
    total++; if (bus.Hi !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL ignore_hi: got %h want FFFFFFFF", bus.Hi); end
    total++; if (bus.Lo !== 32'hFFFFFFEB) begin bad++; $display("[TB] FAIL ignore_lo: got %h want FFFFFFEB", bus.Lo); end
  endtask

  task automatic test_reset_abort;
    int doneSeen = 0;
    drive(OP_MULT, 32'd9, 32'd9);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", bus.Busy); end
    total++; if (bus.Hi !== 32'h0) begin bad++; $display("[TB] FAIL abort_hi: got %h want 0", bus.Hi); end
    total++; if (bus.Lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_lo: got %h want 0", bus.Lo); end
    for (int i = 0; i < 40; i++) begin
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) doneSeen++;
      @(negedge clk);
    end
    total++; if (doneSeen !== 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d active cycles want 0", doneSeen); end
    total++; if (bus.Lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_lo_later: got %h want 0", bus.Lo); end
  endtask

  task automatic test_back_to_back;
    int cyc, early;
    runOp(OP_MULT, 32'd3, 32'd4, cyc, early);
    total++; if (bus.Lo !== 32'h0000000C) begin bad++; $display("[TB] FAIL b2b_first_lo: got %h want 0000000C", bus.Lo); end
    runOp(OP_MULT, 32'h00010000, 32'h00010000, cyc, early);
    total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL b2b_busy_cycles: got %0d want 33", cyc); end
    total++; if (bus.Done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done: got %b want 1", bus.Done); end
    total++; if (bus.Hi !== 32'h00000001) begin bad++; $display("[TB] FAIL b2b_hi: got %h want 00000001", bus.Hi); end
    total++; if (bus.Lo !== 32'h00000000) begin bad++; $display("[TB] FAIL b2b_lo: got %h want 00000000", bus.Lo); end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    reset       = 1'b1;
    bus.OpValid = 1'b0;
    bus.Op      = OP_MULT;
    bus.OpA     = '0;
    bus.OpB     = '0;
    @(negedge clk);
    test_reset();
    test_mult_basic();
    test_mult_vectors();
    test_div_vectors();
    test_div_zero();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
